// File: rtl/loop_gear_ctrl.sv
// Lock-acquisition sequencer for the QPSK carrier/timing loop filter: measures windowed
// |pd| energy, flushes/holds the loop while re-acquiring and gear-shifts gain on lock.
module loop_gear_ctrl #(
  parameter int PD_W        = 17,
  parameter int WIN_BIT     = 6,
  parameter int FLUSH_CYC   = 64,
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_CNT  = 2,
  parameter int TIMEOUT_WIN = 255,
  parameter int ACQ_SHIFT   = 0,
  parameter int TRK_SHIFT   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    pd_valid_i,
  input  logic [PD_W-1:0]         pd_i,
  input  logic [PD_W+WIN_BIT-1:0] lock_thr_i,
  input  logic [PD_W+WIN_BIT-1:0] unlock_thr_i,
  output logic                    lf_flush_o,
  output logic                    nco_hold_o,
  output logic [2:0]              gain_shift_o,
  output logic                    locked_o,
  output logic [1:0]              state_o,
  output logic                    acq_timeout_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, ACQ = 2'd2, TRACK = 2'd3} state_t;

  localparam int SUM_W = PD_W + WIN_BIT;
  localparam int FC_W  = $clog2(FLUSH_CYC + 1);
  localparam int GC_W  = $clog2(LOCK_CNT + 1);
  localparam int BC_W  = $clog2(UNLOCK_CNT + 1);
  localparam int AW_W  = $clog2(TIMEOUT_WIN + 1);

  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYC - 1);
  localparam logic [GC_W-1:0] LOCK_N     = GC_W'(LOCK_CNT);
  localparam logic [BC_W-1:0] UNLOCK_N   = BC_W'(UNLOCK_CNT);
  localparam logic [AW_W-1:0] TMO_N      = AW_W'(TIMEOUT_WIN);
  localparam logic [2:0]      ACQ_G      = 3'(ACQ_SHIFT);
  localparam logic [2:0]      TRK_G      = 3'(TRK_SHIFT);

  state_t             state_q, state_d;
  logic [FC_W-1:0]    fcnt_q, fcnt_d;
  logic [WIN_BIT-1:0] win_q, win_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [GC_W-1:0]    good_q, good_d, good_n;
  logic [BC_W-1:0]    bad_q, bad_d, bad_n;
  logic [AW_W-1:0]    awin_q, awin_d, awin_n;
  logic               tmo_d;
  logic               lf_flush_q, nco_hold_q, locked_q, tmo_q;
  logic [2:0]         gain_shift_q;

  logic [PD_W-1:0]    pd_abs;
  logic [SUM_W-1:0]   sum;
  logic               run, win_end;

  // Two's-complement negate on PD_W bits: the most negative code maps to 2**(PD_W-1) unsigned.
  assign pd_abs  = pd_i[PD_W-1] ? (~pd_i + PD_W'(1)) : pd_i;
  assign sum     = acc_q + SUM_W'(pd_abs);
  assign run     = (state_q == ACQ) || (state_q == TRACK);
  assign win_end = run && pd_valid_i && (win_q == '1);

  always_comb begin
    state_d = state_q;
    fcnt_d  = (state_q == FLUSH) ? fcnt_q + FC_W'(1) : '0;
    win_d   = win_q;
    acc_d   = acc_q;
    good_d  = good_q;
    bad_d   = bad_q;
    awin_d  = awin_q;
    tmo_d   = 1'b0;
    good_n  = (sum < lock_thr_i)   ? good_q + GC_W'(1) : '0;
    bad_n   = (sum > unlock_thr_i) ? bad_q + BC_W'(1)  : '0;
    awin_n  = awin_q + AW_W'(1);

    if (run && pd_valid_i) begin
      win_d = win_q + WIN_BIT'(1);
      acc_d = win_end ? '0 : sum;
    end

    case (state_q)
      IDLE:  if (en_i) state_d = FLUSH;
      FLUSH: if (fcnt_q == FLUSH_LAST) state_d = ACQ;
      ACQ: if (win_end) begin
        good_d = good_n;
        if (good_n == LOCK_N) begin
          state_d = TRACK;
        end else begin
          awin_d = awin_n;
          if (awin_n == TMO_N) begin
            state_d = FLUSH;
            tmo_d   = 1'b1;
          end
        end
      end
      TRACK: if (win_end) begin
        bad_d = bad_n;
        if (bad_n == UNLOCK_N) state_d = FLUSH;
      end
      default: state_d = IDLE;
    endcase

    // Disable beats any window decision on the same edge.
    if (!en_i) begin
      state_d = IDLE;
      tmo_d   = 1'b0;
    end

    if (state_d != state_q) begin
      fcnt_d = '0;
      win_d  = '0;
      acc_d  = '0;
      good_d = '0;
      bad_d  = '0;
      awin_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fcnt_q       <= '0;
      win_q        <= '0;
      acc_q        <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      awin_q       <= '0;
      lf_flush_q   <= 1'b1;
      nco_hold_q   <= 1'b1;
      gain_shift_q <= ACQ_G;
      locked_q     <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      win_q        <= win_d;
      acc_q        <= acc_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      awin_q       <= awin_d;
      lf_flush_q   <= (state_d == IDLE) || (state_d == FLUSH);
      nco_hold_q   <= (state_d == IDLE) || (state_d == FLUSH);
      gain_shift_q <= (state_d == TRACK) ? TRK_G : ACQ_G;
      locked_q     <= (state_d == TRACK);
      tmo_q        <= tmo_d;
    end
  end

  assign state_o       = state_q;
  assign lf_flush_o    = lf_flush_q;
  assign nco_hold_o    = nco_hold_q;
  assign gain_shift_o  = gain_shift_q;
  assign locked_o      = locked_q;
  assign acq_timeout_o = tmo_q;

endmodule
